collision_scanner: RTL and testbench
====================================

Name: collision_scanner

Overview:
- Parametrised successor to the per-frame player/obstacle collision check. Once per refresh_tick it snapshots the player square and up to NUM_OBJ obstacle squares, then scans the obstacles sequentially, one per clock.
- Manages a lives counter with post-hit invulnerability frames and drives the game-alive status.
- Sits between the object-position generator and the game FSM / VGA overlay logic.

Parameters:
- NUM_OBJ, 16, number of obstacle slots scanned per frame (1..64).
- COORD_W, 10, width of each x/y coordinate.
- SQUARE_SIZE, 30, edge length in pixels of the player and every obstacle.
- LIVES, 3, lives loaded at reset (1..15).
- IFRAMES, 2, frames after a counted hit during which hits are ignored (0 = none).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- refresh_tick  in  1  one-cycle frame strobe.
- player_pos  in  2*COORD_W  player top-left; x = [COORD_W-1:0], y = [2*COORD_W-1:COORD_W].
- obj_pos  in  NUM_OBJ*2*COORD_W  obstacle k top-left at slice k*2*COORD_W; same x/y packing as player_pos.
- obj_valid  in  NUM_OBJ  per-slot enable; 0 = slot ignored.
- status  out  1  1 = alive, 0 = game over (sticky).
- hit  out  1  one-cycle pulse: a hit was counted this frame.
- hit_idx  out  clog2(NUM_OBJ) (min 1)  lowest colliding slot index of the last counted hit.
- lives  out  4  remaining lives.
- busy  out  1  high while the scan is in progress.
- overrun  out  1  sticky: refresh_tick arrived while busy.

Behaviour:
- Reset values, applied on any clk edge with reset=1, including mid-scan:
  - status=1, hit=0, hit_idx=0, lives=LIVES, busy=0, overrun=0.
  - iframe counter=0, FSM=IDLE, scan index=0, snapshot registers=0.
- FSM states: IDLE, SCAN, DONE, OVER.
- IDLE:
  - On refresh_tick, register player_pos, obj_pos and obj_valid into snapshot registers, clear the frame-hit flag, set index=0, go to SCAN.
  - busy=1 from the next cycle.
- SCAN:
  - Each cycle, test snapshot slot[index]. index increments each cycle.
  - After index NUM_OBJ-1 is tested, go to DONE. SCAN therefore occupies exactly NUM_OBJ cycles.
  - Inputs changing during SCAN have no effect.
- Overlap test (half-open squares), evaluated in COORD_W+1 bits so there is no wrap:
  - px < ox+SQUARE_SIZE and ox < px+SQUARE_SIZE and py < oy+SQUARE_SIZE and oy < py+SQUARE_SIZE, and valid[k]=1.
  - Touching edges (ox = px+SQUARE_SIZE) is not a hit. Coordinates near 2^COORD_W-1 must not wrap.
- Hit index: the first overlapping slot in scan order is latched as the candidate index. Later overlapping slots do not change it.
- DONE (one cycle), busy=0:
  - If frame_hit=1 and iframe counter=0: hit=1 for this cycle, hit_idx=candidate, lives decremented, iframe counter loaded with IFRAMES.
  - Else if iframe counter>0: counter decremented (once per frame, whether or not a hit occurred).
  - If lives becomes 0: status=0 and go to OVER. Otherwise return to IDLE.
- Latency: refresh_tick sampled at edge T. SCAN spans edges T+1..T+NUM_OBJ. DONE outputs (hit, lives, status, hit_idx) are visible after edge T+NUM_OBJ+1.
- OVER:
  - status=0 and lives=0 held; hit stays 0.
  - refresh_tick is ignored and does not set overrun.
  - Only reset leaves OVER.
- Overrun: a refresh_tick seen in SCAN or DONE sets overrun=1 (sticky until reset). That tick is dropped, not queued.
- lives never underflows. LIVES=1 means the first counted hit ends the game.

Test Plan:
- No overlap: player (100,100), all obstacles at (300,300) with valid all 1s, one tick -> busy high for 16 cycles, hit never pulses, lives=3, status=1.
- Edge/overlap boundary: obstacle 5 at (130,100) -> no hit. Moved to (129,100) -> hit pulse exactly at T+17, hit_idx=5, lives=2.
- Multiple hits plus valid mask: slots 3 and 9 overlap; first frame with valid[3]=0 -> hit_idx=9. After iframes expire, next frame with valid[3]=1 -> hit_idx=3.
- Invulnerability, IFRAMES=2, with a persistent overlap:
  - Frame 1 -> hit, lives 3->2.
  - Frames 2 and 3 -> no hit.
  - Frame 4 -> hit, lives 2->1.
  - Frame 7 -> lives 0, status=0, FSM in OVER.
  - Further ticks -> no change.
- Wrap check: player (1010,1010), obstacle (5,5) with COORD_W=10 -> no hit.
- Overrun and reset: tick issued at scan cycle 4 -> overrun=1 and the scan result is unaffected. Reset asserted mid-scan -> all outputs return to reset values on the next edge and busy=0.

Source files
------------

// File: rtl/collision_scanner.sv
// collision_scanner: per-frame player/obstacle overlap scan with lives,
// post-hit invulnerability frames and a sticky game-over status.
//
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   refresh_tick    - one-cycle frame strobe that starts a scan
//   player_pos      - player top-left, x = [COORD_W-1:0], y = upper half
//   obj_pos         - NUM_OBJ obstacle top-lefts, slot k at k*2*COORD_W
//   obj_valid       - per-slot enable
//   status          - 1 = alive, 0 = game over (sticky)
//   hit             - one-cycle pulse when a hit is counted
//   hit_idx         - lowest colliding slot of the last counted hit
//   lives           - remaining lives
//   busy            - scan in progress
//   overrun         - sticky: a frame strobe arrived while busy
module collision_scanner #(
    parameter int NUM_OBJ     = 16,
    parameter int COORD_W     = 10,
    parameter int SQUARE_SIZE = 30,
    parameter int LIVES       = 3,
    parameter int IFRAMES     = 2,
    localparam int IDX_W      = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         refresh_tick,
    input  logic [2*COORD_W-1:0]         player_pos,
    input  logic [NUM_OBJ*2*COORD_W-1:0] obj_pos,
    input  logic [NUM_OBJ-1:0]           obj_valid,
    output logic                         status,
    output logic                         hit,
    output logic [IDX_W-1:0]             hit_idx,
    output logic [3:0]                   lives,
    output logic                         busy,
    output logic                         overrun
);

    localparam int FW = (IFRAMES > 0) ? $clog2(IFRAMES + 1) : 1;
    localparam int PW = 2 * COORD_W;

    localparam logic [COORD_W:0] SQ      = (COORD_W + 1)'(SQUARE_SIZE);
    localparam logic [FW-1:0]    IF_LOAD = FW'(IFRAMES);
    localparam logic [IDX_W-1:0] LAST    = IDX_W'(NUM_OBJ - 1);
    localparam logic [3:0]       LIVES_I = 4'(LIVES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE,
        S_OVER
    } state_t;

    state_t                     state;
    logic [IDX_W-1:0]           idx;
    logic [IDX_W-1:0]           cand;
    logic                       frame_hit;
    logic [FW-1:0]              iframe;
    logic [PW-1:0]              snap_player;
    logic [NUM_OBJ*PW-1:0]      snap_obj;
    logic [NUM_OBJ-1:0]         snap_valid;

    logic [PW-1:0]              cur_obj;
    logic [COORD_W:0]           px;
    logic [COORD_W:0]           py;
    logic [COORD_W:0]           ox;
    logic [COORD_W:0]           oy;
    logic                       overlap;
    logic [3:0]                 lives_dec;

    assign cur_obj = snap_obj[int'(idx)*PW +: PW];

    // One extra bit so coordinate + size near the top of the range
    // cannot wrap around to a small value.
    assign px = {1'b0, snap_player[COORD_W-1:0]};
    assign py = {1'b0, snap_player[PW-1:COORD_W]};
    assign ox = {1'b0, cur_obj[COORD_W-1:0]};
    assign oy = {1'b0, cur_obj[PW-1:COORD_W]};

    // Half-open squares: touching edges do not overlap.
    assign overlap = snap_valid[idx]
                   & (px < ox + SQ)
                   & (ox < px + SQ)
                   & (py < oy + SQ)
                   & (oy < py + SQ);

    assign lives_dec = lives - 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            cand        <= '0;
            frame_hit   <= 1'b0;
            iframe      <= '0;
            snap_player <= '0;
            snap_obj    <= '0;
            snap_valid  <= '0;
            status      <= 1'b1;
            hit         <= 1'b0;
            hit_idx     <= '0;
            lives       <= LIVES_I;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            hit <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (refresh_tick) begin
                        snap_player <= player_pos;
                        snap_obj    <= obj_pos;
                        snap_valid  <= obj_valid;
                        frame_hit   <= 1'b0;
                        cand        <= '0;
                        idx         <= '0;
                        busy        <= 1'b1;
                        state       <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (refresh_tick) begin
                        overrun <= 1'b1;
                    end
                    // Keep only the first overlapping slot in scan order.
                    if (overlap && !frame_hit) begin
                        frame_hit <= 1'b1;
                        cand      <= idx;
                    end
                    if (idx == LAST) begin
                        idx   <= '0;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (refresh_tick) begin
                        overrun <= 1'b1;
                    end
                    state <= S_IDLE;
                    if (frame_hit && iframe == '0) begin
                        hit     <= 1'b1;
                        hit_idx <= cand;
                        lives   <= lives_dec;
                        iframe  <= IF_LOAD;
                        if (lives_dec == 4'd0) begin
                            status <= 1'b0;
                            state  <= S_OVER;
                        end
                    end else if (iframe != '0) begin
                        // Invulnerability counts frames, hit or not.
                        iframe <= iframe - 1'b1;
                    end
                end
                S_OVER: begin
                    status <= 1'b0;
                    lives  <= 4'd0;
                    busy   <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_collision_scanner.sv
// tb_collision_scanner: directed frames checked every cycle against a
// frame-level behavioural model, plus literal per-scenario expectations.
module tb_collision_scanner;

    localparam int NUM_OBJ = 16;
    localparam int CW      = 10;
    localparam int SQ      = 30;
    localparam int LIVES   = 3;
    localparam int IFRAMES = 2;
    localparam int PW      = 2 * CW;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    refresh_tick;
    logic [PW-1:0]           player_pos;
    logic [NUM_OBJ*PW-1:0]   obj_pos;
    logic [NUM_OBJ-1:0]      obj_valid;
    logic                    status;
    logic                    hit;
    logic [3:0]              hit_idx;
    logic [3:0]              lives;
    logic                    busy;
    logic                    overrun;

    int n_checks = 0;
    int n_err    = 0;

    collision_scanner #(
        .NUM_OBJ    (NUM_OBJ),
        .COORD_W    (CW),
        .SQUARE_SIZE(SQ),
        .LIVES      (LIVES),
        .IFRAMES    (IFRAMES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .refresh_tick(refresh_tick),
        .player_pos  (player_pos),
        .obj_pos     (obj_pos),
        .obj_valid   (obj_valid),
        .status      (status),
        .hit         (hit),
        .hit_idx     (hit_idx),
        .lives       (lives),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     name, $signed(act), $signed(exp), $time);
        end
    endtask

    // ---------------- input capture at each active edge ----------------
    int                  cyc       = 0;
    logic                cap_reset = 1'b1;
    logic                cap_tick  = 1'b0;
    logic [PW-1:0]       cap_player;
    logic [NUM_OBJ*PW-1:0] cap_obj;
    logic [NUM_OBJ-1:0]  cap_valid;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            cap_reset  = reset;
            cap_tick   = refresh_tick;
            cap_player = player_pos;
            cap_obj    = obj_pos;
            cap_valid  = obj_valid;
        end
    end

    // ---------------- frame-level model ----------------
    int m_lives   = LIVES;
    int m_inv     = 0;
    int m_done_at = -1;
    int m_hit_idx = 0;
    int m_cand    = -1;
    bit m_alive   = 1;
    bit m_hit     = 0;
    bit m_ovr     = 0;
    bit m_busy    = 0;

    function automatic int abs_i(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Lowest valid slot whose square overlaps the player, or -1.
    function automatic int first_hit();
        int px, py, ox, oy;
        logic [PW-1:0] s;
        px = int'(cap_player[CW-1:0]);
        py = int'(cap_player[PW-1:CW]);
        for (int k = 0; k < NUM_OBJ; k++) begin
            s  = cap_obj[k*PW +: PW];
            ox = int'(s[CW-1:0]);
            oy = int'(s[PW-1:CW]);
            if (cap_valid[k] && abs_i(px - ox) < SQ && abs_i(py - oy) < SQ)
                return k;
        end
        return -1;
    endfunction

    task automatic model_step();
        bit inflight;
        if (cap_reset) begin
            m_lives   = LIVES;
            m_inv     = 0;
            m_done_at = -1;
            m_hit_idx = 0;
            m_alive   = 1;
            m_hit     = 0;
            m_ovr     = 0;
        end else begin
            m_hit    = 0;
            inflight = (m_done_at >= 0);
            if (cap_tick && inflight) begin
                m_ovr = 1;
            end else if (cap_tick && m_alive) begin
                m_cand    = first_hit();
                m_done_at = cyc + NUM_OBJ + 1;
            end
            if (m_done_at == cyc) begin
                if (m_cand >= 0 && m_inv == 0) begin
                    m_hit     = 1;
                    m_hit_idx = m_cand;
                    m_lives   = m_lives - 1;
                    m_inv     = IFRAMES;
                    if (m_lives == 0) m_alive = 0;
                end else if (m_inv > 0) begin
                    m_inv = m_inv - 1;
                end
                m_done_at = -1;
            end
        end
        m_busy = (m_done_at >= 0) && (cyc < m_done_at - 1);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                model_step();
                chk("status",  status,  m_alive);
                chk("hit",     hit,     m_hit);
                chk("hit_idx", hit_idx, m_hit_idx);
                chk("lives",   lives,   m_lives);
                chk("busy",    busy,    m_busy);
                chk("overrun", overrun, m_ovr);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_obj(input int k, input int x, input int y);
        obj_pos[k*PW +: PW] = {10'(y), 10'(x)};
    endtask

    task automatic all_far();
        for (int k = 0; k < NUM_OBJ; k++) set_obj(k, 300, 300);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Issue one tick; report busy cycles and the negedge index of hit.
    task automatic run_frame(output int busy_cnt, output int hit_at);
        busy_cnt = 0;
        hit_at   = -1;
        @(negedge clk);
        refresh_tick = 1'b1;
        @(negedge clk);
        refresh_tick = 1'b0;
        if (busy) busy_cnt++;
        for (int j = 1; j <= NUM_OBJ + 3; j++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (hit && hit_at < 0) hit_at = j;
        end
    endtask

    int bc, ha;
    int exp_lives[7] = '{2, 2, 2, 1, 1, 1, 0};
    bit exp_hit[7]   = '{1, 0, 0, 1, 0, 0, 1};

    initial begin
        reset        = 1'b1;
        refresh_tick = 1'b0;
        player_pos   = {10'd100, 10'd100};
        obj_pos      = '0;
        obj_valid    = '1;
        all_far();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_status",  status,  1);
        chk("rst_lives",   lives,   3);
        chk("rst_busy",    busy,    0);
        chk("rst_overrun", overrun, 0);
        chk("rst_hit",     hit,     0);
        chk("rst_hit_idx", hit_idx, 0);

        // no overlap
        run_frame(bc, ha);
        chk("clr_busy_cycles", bc, 16);
        chk("clr_hit_at", ha, -1);
        chk("clr_lives", lives, 3);
        chk("clr_status", status, 1);

        // touching edge, then one pixel of overlap
        set_obj(5, 130, 100);
        run_frame(bc, ha);
        chk("edge_hit_at", ha, -1);
        chk("edge_lives", lives, 3);
        set_obj(5, 129, 100);
        run_frame(bc, ha);
        chk("ovl_hit_at", ha, 17);
        chk("ovl_hit_idx", hit_idx, 5);
        chk("ovl_lives", lives, 2);

        // two overlaps with the valid mask
        do_reset();
        all_far();
        set_obj(3, 110, 110);
        set_obj(9, 90, 95);
        obj_valid[3] = 1'b0;
        run_frame(bc, ha);
        chk("mask_hit_at", ha, 17);
        chk("mask_hit_idx", hit_idx, 9);
        chk("mask_lives", lives, 2);
        run_frame(bc, ha);
        chk("inv1_hit_at", ha, -1);
        run_frame(bc, ha);
        chk("inv2_hit_at", ha, -1);
        obj_valid[3] = 1'b1;
        run_frame(bc, ha);
        chk("unmask_hit_at", ha, 17);
        chk("unmask_hit_idx", hit_idx, 3);
        chk("unmask_lives", lives, 1);

        // persistent overlap through invulnerability to game over
        do_reset();
        all_far();
        set_obj(0, 100, 100);
        for (int f = 0; f < 7; f++) begin
            run_frame(bc, ha);
            chk("iframe_hit_at", ha, exp_hit[f] ? 17 : -1);
            chk("iframe_lives", lives, exp_lives[f]);
        end
        chk("over_status", status, 0);
        run_frame(bc, ha);
        chk("over_busy_cycles", bc, 0);
        chk("over_hit_at", ha, -1);
        chk("over_lives", lives, 0);
        chk("over_overrun", overrun, 0);

        // coordinates near the top must not wrap
        do_reset();
        all_far();
        player_pos = {10'd1010, 10'd1010};
        set_obj(0, 5, 5);
        run_frame(bc, ha);
        chk("wrap_hit_at", ha, -1);
        chk("wrap_lives", lives, 3);
        set_obj(1, 1000, 1000);
        run_frame(bc, ha);
        chk("top_hit_at", ha, 17);
        chk("top_hit_idx", hit_idx, 1);

        // overrun mid-scan, inputs changed during scan
        do_reset();
        all_far();
        player_pos = {10'd100, 10'd100};
        set_obj(2, 100, 100);
        @(negedge clk);
        refresh_tick = 1'b1;
        @(negedge clk);
        refresh_tick = 1'b0;
        repeat (3) @(negedge clk);
        refresh_tick = 1'b1;
        @(negedge clk);
        refresh_tick = 1'b0;
        set_obj(2, 300, 300);
        repeat (NUM_OBJ + 2) @(negedge clk);
        chk("ovr_overrun", overrun, 1);
        chk("ovr_hit_idx", hit_idx, 2);
        chk("ovr_lives", lives, 2);
        chk("ovr_status", status, 1);

        // reset in the middle of a scan
        @(negedge clk);
        refresh_tick = 1'b1;
        @(negedge clk);
        refresh_tick = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy_pre", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_busy",    busy,    0);
        chk("mid_overrun", overrun, 0);
        chk("mid_lives",   lives,   3);
        chk("mid_status",  status,  1);
        chk("mid_hit_idx", hit_idx, 0);
        run_frame(bc, ha);
        chk("post_busy_cycles", bc, 16);
        chk("post_hit_at", ha, -1);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
